// File: rtl/gps_count_reader.sv
// ============================================================================
// gps_count_reader
// ----------------------------------------------------------------------------
// SPI master that reads the PPS-gated clock count out of the CPLD frequency
// counter. One read frame is COUNTER_BITS+1 bits, MSB first: a new-data flag
// followed by the count. The result is presented on a parallel bus together
// with a one-cycle done strobe.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   start        request a read (ignored while busy)
//   busy         high from the accepted start until the inter-frame gap ends
//   spi_clk      serial clock to the counter, idles low
//   spi_sen      active-low select, idles high
//   spi_in       serial data from the counter
//   spi_out      serial data to the counter, constant 0
//   count_out    last received count
//   count_valid  flag bit of the last frame (1 = fresh PPS data)
//   done         one-cycle strobe when count_out/count_valid update
//   count_delta  count_out - EXPECTED_COUNT, signed, COUNTER_BITS+1 wide
//
// Configuration macro:
//   GPS_COUNT_READER_DELTA_EN  when defined, count_delta is a registered
//                              difference against EXPECTED_COUNT (0 when the
//                              flag bit is 0); otherwise it is tied to 0.
//
// GAP_CYCLES of 0 is treated as 1 (GAP always lasts at least one cycle).
// ============================================================================
module gps_count_reader #(
   parameter int                      COUNTER_BITS   = 27,
   parameter int                      HALF_PERIOD    = 8,
   parameter int                      SETUP_CYCLES   = 4,
   parameter int                      GAP_CYCLES     = 4,
   parameter logic [COUNTER_BITS-1:0] EXPECTED_COUNT = '0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   output logic                    busy,
   output logic                    spi_clk,
   output logic                    spi_sen,
   input  logic                    spi_in,
   output logic                    spi_out,
   output logic [COUNTER_BITS-1:0] count_out,
   output logic                    count_valid,
   output logic                    done,
   output logic [COUNTER_BITS:0]   count_delta
);

   // Phase timer must hold the largest of the three phase lengths.
   localparam int T_MAX0 = (HALF_PERIOD > SETUP_CYCLES) ? HALF_PERIOD : SETUP_CYCLES;
   localparam int T_MAX  = (T_MAX0 > GAP_CYCLES) ? T_MAX0 : GAP_CYCLES;
   localparam int TW     = $clog2(T_MAX + 1);
   localparam int BW     = $clog2(COUNTER_BITS + 1);

   localparam logic [TW-1:0] SETUP_LOAD = TW'(SETUP_CYCLES - 1);
   localparam logic [TW-1:0] HALF_LOAD  = TW'(HALF_PERIOD - 1);
   localparam logic [TW-1:0] GAP_LOAD   = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, GAP} state_t;

   state_t                  state, state_next;
   logic [TW-1:0]           timer;
   logic [BW-1:0]           bit_cnt;
   logic [COUNTER_BITS:0]   shift_reg;
   logic                    timer_zero;
   logic                    last_bit;
   logic                    frame_end;

   assign timer_zero = (timer == '0);
   assign last_bit   = (bit_cnt == BW'(COUNTER_BITS));
   // Last cycle of the final HIGH phase: the complete frame is in shift_reg.
   assign frame_end  = (state == HIGH) && timer_zero && last_bit;
   assign spi_out    = 1'b0;

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   // NOTE: sequential state is always assigned with <= so every flop samples
   // pre-edge values regardless of the order blocks are evaluated.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   // NOTE: the default assignment at the top keeps every path assigned, so no
   // latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start)      state_next = SETUP;
         SETUP:   if (timer_zero) state_next = LOW;
         LOW:     if (timer_zero) state_next = HIGH;
         HIGH:    if (timer_zero) state_next = last_bit ? GAP : LOW;
         GAP:     if (timer_zero) state_next = IDLE;
         default:                 state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Outputs decoded from the state register only (no path from inputs).
   // ---------------------------------------------------------------------
   always_comb begin
      busy    = (state != IDLE);
      spi_sen = !(state inside {SETUP, LOW, HIGH});
      spi_clk = (state == HIGH);
   end

   // ---------------------------------------------------------------------
   // Phase timer, bit counter, receive shift register and parallel outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer       <= '0;
         bit_cnt     <= '0;
         shift_reg   <= '0;
         count_out   <= '0;
         count_valid <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  timer   <= SETUP_LOAD;
                  bit_cnt <= '0;
               end
            end
            SETUP: timer <= timer_zero ? HALF_LOAD : timer - 1'b1;
            LOW: begin
               if (timer_zero) begin
                  timer <= HALF_LOAD;
                  // Sample at the end of LOW: the slave shifted on the
                  // previous rising edge, so data has had a full HIGH+LOW
                  // interval to settle.
                  shift_reg <= {shift_reg[COUNTER_BITS-1:0], spi_in};
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            HIGH: begin
               if (timer_zero) begin
                  if (last_bit) begin
                     timer       <= GAP_LOAD;
                     count_valid <= shift_reg[COUNTER_BITS];
                     count_out   <= shift_reg[COUNTER_BITS-1:0];
                     done        <= 1'b1;
                  end else begin
                     timer   <= HALF_LOAD;
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            GAP: if (!timer_zero) timer <= timer - 1'b1;
            default: ;
         endcase
      end
   end

`ifdef GPS_COUNT_READER_DELTA_EN
   // Zero-extended count minus nominal, two's complement at COUNTER_BITS+1.
   // Stale (flag=0) frames report 0 so the host never acts on old data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_delta <= '0;
      end else if (frame_end) begin
         count_delta <= shift_reg[COUNTER_BITS]
                        ? ({1'b0, shift_reg[COUNTER_BITS-1:0]} - {1'b0, EXPECTED_COUNT})
                        : '0;
      end
   end
`else
   assign count_delta = '0;
`endif

endmodule

// File: tb/tb_gps_count_reader.sv
// ============================================================================
// tb_gps_count_reader
// Three reader instances (HALF_PERIOD 8, 2, 16) share clk/reset. A
// cycle-based behavioural model of the counter's SPI slave serves whichever
// instance a test drives, and checks the serial protocol timing.
// ============================================================================
module tb_gps_count_reader;

   localparam int  N        = 27;
   localparam int  SETUP    = 4;
   localparam int  GAP      = 4;
   localparam longint EXP_MAIN = 19200000;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic        start_v  [3];
   logic        spi_in_v [3];
   logic        busy_v   [3];
   logic        sclk_v   [3];
   logic        sen_v    [3];
   logic        sout_v   [3];
   logic        done_v   [3];
   logic        vld_v    [3];
   logic [N-1:0] cnt_v   [3];
   logic [N:0]   dlt_v   [3];

   // slave model state: what the counter would return on the next read
   logic         slv_flag [3];
   logic [N-1:0] slv_cnt  [3];

   int errors = 0;
   int checks = 0;

   // results of the last run_frame
   int           r_n_done, r_n_sen, r_busy_fall, r_rises, r_viol;
   int           r_done_cyc [2];
   int           r_sen_cyc  [2];
   logic         r_vld      [2];
   logic [N-1:0] r_cnt      [2];
   logic [N:0]   r_dlt      [2];
   logic         ab_sen, ab_clk, ab_busy, ab_done, ab_vld;
   logic [N-1:0] ab_cnt;
   logic [N:0]   ab_dlt;

   always #5 clk = ~clk;

   gps_count_reader #(.COUNTER_BITS(N), .HALF_PERIOD(8), .SETUP_CYCLES(SETUP),
                      .GAP_CYCLES(GAP), .EXPECTED_COUNT(N'(EXP_MAIN))) dut (
      .clk(clk), .reset(reset), .start(start_v[0]), .busy(busy_v[0]),
      .spi_clk(sclk_v[0]), .spi_sen(sen_v[0]), .spi_in(spi_in_v[0]),
      .spi_out(sout_v[0]), .count_out(cnt_v[0]), .count_valid(vld_v[0]),
      .done(done_v[0]), .count_delta(dlt_v[0]));

   gps_count_reader #(.COUNTER_BITS(N), .HALF_PERIOD(2), .SETUP_CYCLES(SETUP),
                      .GAP_CYCLES(GAP), .EXPECTED_COUNT('0)) dut_h2 (
      .clk(clk), .reset(reset), .start(start_v[1]), .busy(busy_v[1]),
      .spi_clk(sclk_v[1]), .spi_sen(sen_v[1]), .spi_in(spi_in_v[1]),
      .spi_out(sout_v[1]), .count_out(cnt_v[1]), .count_valid(vld_v[1]),
      .done(done_v[1]), .count_delta(dlt_v[1]));

   gps_count_reader #(.COUNTER_BITS(N), .HALF_PERIOD(16), .SETUP_CYCLES(SETUP),
                      .GAP_CYCLES(GAP), .EXPECTED_COUNT('0)) dut_h16 (
      .clk(clk), .reset(reset), .start(start_v[2]), .busy(busy_v[2]),
      .spi_clk(sclk_v[2]), .spi_sen(sen_v[2]), .spi_in(spi_in_v[2]),
      .spi_out(sout_v[2]), .count_out(cnt_v[2]), .count_valid(vld_v[2]),
      .done(done_v[2]), .count_delta(dlt_v[2]));

   function automatic int hp_of(input int sel);
      return (sel == 0) ? 8 : (sel == 1) ? 2 : 16;
   endfunction

   function automatic longint exp_of(input int sel);
      return (sel == 0) ? EXP_MAIN : 0;
   endfunction

   // Expected done cycle, start driven on cycle 0.
   function automatic int done_at(input int sel);
      return 1 + SETUP + (N + 1) * 2 * hp_of(sel);
   endfunction

   function automatic logic [N:0] model_delta(input logic f, input logic [N-1:0] c,
                                              input longint e);
`ifdef GPS_COUNT_READER_DELTA_EN
      longint d;
      if (!f) return '0;
      d = longint'(c) - e;
      return d[N:0];
`else
      return '0;
`endif
   endfunction

   // A PPS event at the slave: latch a fresh count with the flag set.
   task automatic pps(input int sel, input logic [N-1:0] c);
      slv_flag[sel] = 1'b1;
      slv_cnt[sel]  = c;
   endtask

   // Drive one read (or more, when start is held) on instance sel for
   // `window` cycles while playing the slave and checking protocol timing.
   task automatic run_frame(input int sel, input int window, input bit hold,
                            input int second_at, input int abort_at);
      logic [N:0] frame;
      int idx, last_edge, fall_cyc;
      bit first_pend;
      logic p_sen, p_clk, p_busy;
      int hp;
      hp = hp_of(sel);
      r_n_done = 0; r_n_sen = 0; r_busy_fall = 0; r_rises = 0; r_viol = 0;
      frame = '0; idx = N + 1; last_edge = 0; fall_cyc = 0; first_pend = 1'b0;
      @(negedge clk);
      p_sen = sen_v[sel]; p_clk = sclk_v[sel]; p_busy = busy_v[sel];
      start_v[sel] = 1'b1;
      for (int c = 1; c <= window; c++) begin
         @(posedge clk);
         #1;
         if (sen_v[sel] && sclk_v[sel]) r_viol++;
         if (sout_v[sel] !== 1'b0) r_viol++;
         if (p_sen && !sen_v[sel]) begin
            frame = {slv_flag[sel], slv_cnt[sel]};
            idx = 0;
            if (r_n_sen < 2) r_sen_cyc[r_n_sen] = c;
            r_n_sen++;
            fall_cyc = c;
            first_pend = 1'b1;
         end
         if (!p_clk && sclk_v[sel]) begin
            r_rises++;
            if (first_pend) begin
               if (c - fall_cyc != SETUP + hp) r_viol++;
               first_pend = 1'b0;
            end else if (c - last_edge != hp) begin
               r_viol++;
            end
            last_edge = c;
            idx++;
         end
         if (p_clk && !sclk_v[sel]) begin
            if (c - last_edge != hp) r_viol++;
            last_edge = c;
         end
         // A complete read consumes the slave's data.
         if (!p_sen && sen_v[sel] && idx == N + 1) begin
            slv_flag[sel] = 1'b0;
            slv_cnt[sel]  = '0;
         end
         spi_in_v[sel] = (idx <= N) ? frame[N - idx] : 1'b0;
         if (done_v[sel]) begin
            if (r_n_done < 2) begin
               r_done_cyc[r_n_done] = c;
               r_vld[r_n_done] = vld_v[sel];
               r_cnt[r_n_done] = cnt_v[sel];
               r_dlt[r_n_done] = dlt_v[sel];
            end
            r_n_done++;
         end
         if (p_busy && !busy_v[sel] && r_busy_fall == 0) r_busy_fall = c;
         p_sen = sen_v[sel]; p_clk = sclk_v[sel]; p_busy = busy_v[sel];
         start_v[sel] = hold ? (r_n_sen < 2) : (c == second_at - 1);
         if (c == abort_at) begin
            reset = 1'b1;
            #1;
            ab_sen = sen_v[sel]; ab_clk = sclk_v[sel]; ab_busy = busy_v[sel];
            ab_done = done_v[sel]; ab_vld = vld_v[sel];
            ab_cnt = cnt_v[sel]; ab_dlt = dlt_v[sel];
            #2;
            reset = 1'b0;
            spi_in_v[sel] = 1'b0;
            break;
         end
      end
      start_v[sel] = 1'b0;
      for (int k = 0; k < 3000 && busy_v[sel]; k++) @(posedge clk);
      #1;
      checks++;
      if (busy_v[sel] !== 1'b0) begin
         errors++;
         $display("FAIL busy_timeout: busy=%0b after cycle budget, required 0", busy_v[sel]);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks += 8;
      if (busy_v[0] !== 1'b0)  begin errors++; $display("FAIL rst_busy: got %0b want 0", busy_v[0]); end
      if (sclk_v[0] !== 1'b0)  begin errors++; $display("FAIL rst_spi_clk: got %0b want 0", sclk_v[0]); end
      if (sen_v[0] !== 1'b1)   begin errors++; $display("FAIL rst_spi_sen: got %0b want 1", sen_v[0]); end
      if (sout_v[0] !== 1'b0)  begin errors++; $display("FAIL rst_spi_out: got %0b want 0", sout_v[0]); end
      if (cnt_v[0] !== '0)     begin errors++; $display("FAIL rst_count_out: got %0h want 0", cnt_v[0]); end
      if (vld_v[0] !== 1'b0)   begin errors++; $display("FAIL rst_count_valid: got %0b want 0", vld_v[0]); end
      if (done_v[0] !== 1'b0)  begin errors++; $display("FAIL rst_done: got %0b want 0", done_v[0]); end
      if (dlt_v[0] !== '0)     begin errors++; $display("FAIL rst_count_delta: got %0h want 0", dlt_v[0]); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // Common checks on the first frame of the last run.
   task automatic check_frame(input string nm, input int sel, input logic ef,
                              input logic [N-1:0] ec);
      logic [N:0] ed;
      ed = model_delta(ef, ec, exp_of(sel));
      checks += 6;
      if (r_n_done !== 1) begin errors++; $display("FAIL %s_done_count: got %0d want 1", nm, r_n_done); end
      if (r_done_cyc[0] !== done_at(sel)) begin errors++; $display("FAIL %s_done_cycle: got %0d want %0d", nm, r_done_cyc[0], done_at(sel)); end
      if (r_vld[0] !== ef) begin errors++; $display("FAIL %s_count_valid: got %0b want %0b", nm, r_vld[0], ef); end
      if (r_cnt[0] !== ec) begin errors++; $display("FAIL %s_count_out: got %0h want %0h", nm, r_cnt[0], ec); end
      if (r_dlt[0] !== ed) begin errors++; $display("FAIL %s_count_delta: got %0h want %0h", nm, r_dlt[0], ed); end
      if (r_viol !== 0) begin errors++; $display("FAIL %s_protocol: got %0d violations want 0", nm, r_viol); end
   endtask

   task automatic test_single_read();
      pps(0, 27'h124F800);
      run_frame(0, 600, 1'b0, 0, 0);
      check_frame("single", 0, 1'b1, 27'h124F800);
      checks += 3;
      if (r_rises !== N + 1) begin errors++; $display("FAIL single_rises: got %0d want %0d", r_rises, N + 1); end
      if (r_busy_fall !== done_at(0) + GAP) begin errors++; $display("FAIL single_busy_fall: got %0d want %0d", r_busy_fall, done_at(0) + GAP); end
      // outputs hold after the frame
      if (cnt_v[0] !== 27'h124F800) begin errors++; $display("FAIL single_hold: got %0h want %0h", cnt_v[0], 27'h124F800); end
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] c;
      c = N'($urandom);
      pps(0, c);
      run_frame(0, 960, 1'b1, 0, 0);
      checks += 7;
      if (r_n_done !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", r_n_done); end
      if (r_sen_cyc[1] !== done_at(0) + GAP + 1) begin errors++; $display("FAIL b2b_retrigger: got %0d want %0d", r_sen_cyc[1], done_at(0) + GAP + 1); end
      if (r_done_cyc[1] !== 2 * done_at(0) + GAP) begin errors++; $display("FAIL b2b_done2_cycle: got %0d want %0d", r_done_cyc[1], 2 * done_at(0) + GAP); end
      if (r_vld[0] !== 1'b1 || r_cnt[0] !== c) begin errors++; $display("FAIL b2b_first: got %0b/%0h want 1/%0h", r_vld[0], r_cnt[0], c); end
      if (r_vld[1] !== 1'b0) begin errors++; $display("FAIL b2b_valid2: got %0b want 0", r_vld[1]); end
      if (r_cnt[1] !== '0) begin errors++; $display("FAIL b2b_count2: got %0h want 0", r_cnt[1]); end
      if (r_viol !== 0) begin errors++; $display("FAIL b2b_protocol: got %0d want 0", r_viol); end
   endtask

   task automatic test_ignored_start();
      pps(0, 27'h5A5A5A5);
      run_frame(0, 700, 1'b0, 200, 0);
      check_frame("ignored", 0, 1'b1, 27'h5A5A5A5);
      checks += 1;
      if (r_n_sen !== 1) begin errors++; $display("FAIL ignored_frames: got %0d want 1", r_n_sen); end
   endtask

   task automatic test_mid_reset();
      logic [N-1:0] c;
      c = N'($urandom) | 27'h1;
      pps(0, c);
      run_frame(0, 600, 1'b0, 0, 120);
      checks += 7;
      if (ab_sen !== 1'b1)  begin errors++; $display("FAIL abort_spi_sen: got %0b want 1", ab_sen); end
      if (ab_clk !== 1'b0)  begin errors++; $display("FAIL abort_spi_clk: got %0b want 0", ab_clk); end
      if (ab_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b want 0", ab_busy); end
      if (ab_done !== 1'b0) begin errors++; $display("FAIL abort_done: got %0b want 0", ab_done); end
      if (ab_vld !== 1'b0)  begin errors++; $display("FAIL abort_valid: got %0b want 0", ab_vld); end
      if (ab_cnt !== '0)    begin errors++; $display("FAIL abort_count: got %0h want 0", ab_cnt); end
      if (ab_dlt !== '0)    begin errors++; $display("FAIL abort_delta: got %0h want 0", ab_dlt); end
      // aborted read did not consume the slave's data
      run_frame(0, 600, 1'b0, 0, 0);
      check_frame("after_abort", 0, 1'b1, c);
   endtask

   task automatic test_delta();
      pps(0, N'(19199990));
      run_frame(0, 600, 1'b0, 0, 0);
      check_frame("delta_m10", 0, 1'b1, N'(19199990));
      pps(0, N'(19200000));
      run_frame(0, 600, 1'b0, 0, 0);
      check_frame("delta_zero", 0, 1'b1, N'(19200000));
   endtask

   task automatic test_random_h2();
      logic ef;
      logic [N-1:0] ec;
      for (int i = 0; i < 6; i++) begin
         if ($urandom_range(0, 2) != 0) pps(1, N'($urandom));
         ef = slv_flag[1];
         ec = slv_cnt[1];
         run_frame(1, 130, 1'b0, 0, 0);
         check_frame("rand_h2", 1, ef, ec);
      end
   endtask

   task automatic test_protocol_h16();
      pps(2, N'($urandom));
      begin
         logic [N-1:0] ec;
         ec = slv_cnt[2];
         run_frame(2, 960, 1'b0, 0, 0);
         check_frame("h16", 2, 1'b1, ec);
      end
      checks += 1;
      if (r_rises !== N + 1) begin errors++; $display("FAIL h16_rises: got %0d want %0d", r_rises, N + 1); end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0; spi_in_v[i] = 1'b0;
         slv_flag[i] = 1'b0; slv_cnt[i] = '0;
      end
      repeat (3) @(posedge clk);
      test_reset();
      test_single_read();
      test_back_to_back();
      test_ignored_start();
      test_mid_reset();
      test_delta();
      test_random_h2();
      test_protocol_h16();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
